pes_alu_ctrl: RTL and testbench

- Issue and capture controller that sits directly upstream of the 8-bit registered ALU (`pes_alu`).
- Accepts {op, A, B} commands over a valid/ready interface and buffers them in a command FIFO.
- Drives the ALU operand/op inputs from registers, then captures the ALU result exactly one cycle after the ALU samples it.
- Presents each result, with its op and a sequence tag, on a valid/ready result interface. Results leave strictly in command order.

---
 rtl/pes_alu_ctrl.sv | 97 +++++++++
 tb/tb_pes_alu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_alu_ctrl.sv
// pes_alu_ctrl: command FIFO, credit-limited issue to a registered 8-bit ALU,
// and in-order result capture into a result FIFO.
module pes_alu_ctrl #(
    parameter int CDEPTH = 4,
    parameter int RDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [7:0] cmd_a_i,
    input  logic [7:0] cmd_b_i,
    output logic [7:0] alu_a_o,
    output logic [7:0] alu_b_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_r_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_data_o,
    output logic [2:0] res_op_o,
    output logic [7:0] res_seq_o,
    output logic       busy_o
);
    localparam int CW = $clog2(CDEPTH);
    localparam int RW = $clog2(RDEPTH);
    localparam logic [CW:0] C1 = 1;
    localparam logic [RW:0] R1 = 1;

    logic [18:0]   cmem [CDEPTH];
    logic [18:0]   rmem [RDEPTH];
    logic [CW:0]   cwr_q, crd_q;
    logic [RW:0]   rwr_q, rrd_q, res_cnt;
    logic [RW+1:0] used;
    logic          rdy_q, s1_q, s2_q;
    logic [10:0]   s1_tag_q, s2_tag_q;
    logic [7:0]    seq_q, alu_a_q, alu_b_q;
    logic [2:0]    alu_op_q;
    logic [18:0]   chead, rhead;
    logic          cmd_empty, cmd_full, res_empty, push, issue, pop;

    assign cmd_empty   = cwr_q == crd_q;
    assign cmd_full    = (cwr_q[CW] != crd_q[CW]) && (cwr_q[CW-1:0] == crd_q[CW-1:0]);
    assign res_empty   = rwr_q == rrd_q;
    assign res_cnt     = rwr_q - rrd_q;
    // Credit counts every result that will eventually land in the result FIFO.
    assign used        = {1'b0, res_cnt} + (RW+2)'(s1_q) + (RW+2)'(s2_q);
    assign cmd_ready_o = rdy_q && !cmd_full;
    assign push        = cmd_valid_i && cmd_ready_o;
    assign issue       = !cmd_empty && (used < (RW+2)'(RDEPTH));
    assign res_valid_o = !res_empty;
    assign pop         = res_valid_o && res_ready_i;
    assign chead       = cmem[crd_q[CW-1:0]];
    assign rhead       = res_valid_o ? rmem[rrd_q[RW-1:0]] : '0;
    assign {res_data_o, res_op_o, res_seq_o} = rhead;
    assign {alu_a_o, alu_b_o, alu_op_o} = {alu_a_q, alu_b_q, alu_op_q};
    assign busy_o      = !cmd_empty || s1_q || s2_q || !res_empty;

    always_ff @(posedge clk) begin
        if (push) cmem[cwr_q[CW-1:0]] <= {cmd_op_i, cmd_a_i, cmd_b_i};
        if (s2_q) rmem[rwr_q[RW-1:0]] <= {alu_r_i, s2_tag_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            cwr_q    <= '0;
            crd_q    <= '0;
            rwr_q    <= '0;
            rrd_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s1_tag_q <= '0;
            s2_tag_q <= '0;
            seq_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (push) cwr_q <= cwr_q + C1;
            if (issue) begin
                crd_q    <= crd_q + C1;
                alu_op_q <= chead[18:16];
                alu_a_q  <= chead[15:8];
                alu_b_q  <= chead[7:0];
                s1_tag_q <= {chead[18:16], seq_q};
                seq_q    <= seq_q + 8'd1;
            end
            s1_q     <= issue;
            s2_q     <= s1_q;
            s2_tag_q <= s1_tag_q;
            if (s2_q) rwr_q <= rwr_q + R1;
            if (pop) rrd_q <= rrd_q + R1;
        end
    end
endmodule

// File: tb/tb_pes_alu_ctrl.sv
// tb_pes_alu_ctrl: drives pes_alu_ctrl with a behavioural ALU and checks results
// against an in-order queue of expected {data, op, seq}.
module tb_pes_alu_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, res_valid, res_ready, busy;
    logic [2:0] cmd_op, alu_op, res_op;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_r, res_data, res_seq;

    logic [18:0] exp_q [$];
    logic [7:0]  seq_m;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pes_alu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_r_i(alu_r),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_op_o(res_op), .res_seq_o(res_seq),
        .busy_o(busy)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ~a;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return a & b;
            3'd6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    initial alu_r = 8'h00;
    always_ff @(posedge clk) alu_r <= alu_f(alu_op, alu_a, alu_b);

    // Called at a falling edge with inputs settled; books the coming rising edge into the model.
    task automatic tick(output logic acc, output logic pp, output logic [18:0] got, output logic [18:0] ex);
        acc = cmd_valid && cmd_ready;
        pp  = res_valid && res_ready;
        got = {res_data, res_op, res_seq};
        ex  = 'x;
        if (pp && exp_q.size() > 0) ex = exp_q.pop_front();
        if (acc) begin
            exp_q.push_back({alu_f(cmd_op, cmd_a, cmd_b), cmd_op, seq_m});
            seq_m = seq_m + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        total++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b%b exp=000", cmd_ready, res_valid, busy);
        end
        total++;
        if ({alu_a, alu_b, alu_op, res_data, res_op, res_seq} !== '0) begin
            bad++; $display("FAIL reset_values got=%h exp=0", {alu_a, alu_b, alu_op, res_data, res_op, res_seq});
        end
        rst_n = 1'b1;
        exp_q.delete();
        seq_m = 8'd0;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_at_release got=%b exp=0", cmd_ready); end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_single_add;
        logic acc, pp;
        logic [18:0] got, ex;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'hF0; cmd_b = 8'h20;
        tick(acc, pp, got, ex);
        cmd_valid = 1'b0;
        total++;
        if (acc !== 1'b1 || busy !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL add_accept got=%b%b%b exp=110", acc, busy, res_valid);
        end
        tick(acc, pp, got, ex);
        total++;
        if ({alu_a, alu_b, alu_op} !== {8'hF0, 8'h20, 3'd0} || res_valid !== 1'b0) begin
            bad++; $display("FAIL add_issue got=%h %h %h v=%b exp=f0 20 0 v=0", alu_a, alu_b, alu_op, res_valid);
        end
        tick(acc, pp, got, ex);
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early got=%b exp=0", res_valid); end
        tick(acc, pp, got, ex);
        total++;
        if ({res_valid, res_data, res_op, res_seq} !== {1'b1, 8'h10, 3'd0, 8'd0}) begin
            bad++; $display("FAIL add_result got=%b %h %h %h exp=1 10 0 00", res_valid, res_data, res_op, res_seq);
        end
        res_ready = 1'b1;
        tick(acc, pp, got, ex);
        total++;
        if (pp !== 1'b1 || got !== ex) begin bad++; $display("FAIL add_pop got=%h exp=%h", got, ex); end
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL add_idle got=busy%b valid%b exp=busy0 valid0", busy, res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_all_ops;
        logic acc, pp;
        logic [18:0] got, ex;
        logic [7:0] kd [8];
        int n_push = 0, n_pop = 0, first = -1, last = -1;
        kd = '{8'h0C, 8'hFE, 8'hFA, 8'hFA, 8'hF8, 8'h05, 8'h07, 8'h02};
        res_ready = 1'b1; cmd_a = 8'h05; cmd_b = 8'h07;
        for (int c = 0; c < 30 && n_pop < 8; c++) begin
            cmd_valid = n_push < 8;
            cmd_op = 3'(n_push);
            tick(acc, pp, got, ex);
            if (acc) n_push++;
            if (pp) begin
                total++;
                if (got !== ex || got[18:11] !== kd[n_pop]) begin
                    bad++; $display("FAIL all_ops[%0d] got=%h exp=%h data=%h", n_pop, got, ex, kd[n_pop]);
                end
                if (first < 0) first = c;
                last = c;
                n_pop++;
            end
        end
        cmd_valid = 1'b0;
        total++;
        if (n_pop != 8 || first != 4 || last != 11) begin
            bad++; $display("FAIL all_ops_timing got=n%0d first%0d last%0d exp=n8 first4 last11", n_pop, first, last);
        end
    endtask

    task automatic test_backpressure;
        logic acc, pp;
        logic [18:0] got, ex, head;
        logic [18:0] alu_snap;
        int n_push = 0, n_pop = 0;
        res_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cmd_valid = n_push < 10;
            cmd_op = 3'($urandom_range(0, 7)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            tick(acc, pp, got, ex);
            if (acc) n_push++;
        end
        total++;
        if (n_push != 8 || cmd_ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL bp_stall got=push%0d rdy%b v%b busy%b exp=push8 rdy0 v1 busy1", n_push, cmd_ready, res_valid, busy);
        end
        alu_snap = {alu_a, alu_b, alu_op};
        head = {res_data, res_op, res_seq};
        for (int c = 0; c < 4; c++) begin
            cmd_op = 3'($urandom_range(0, 7)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            tick(acc, pp, got, ex);
            if (acc) n_push++;
        end
        total++;
        if ({alu_a, alu_b, alu_op} !== alu_snap || {res_data, res_op, res_seq} !== head || n_push != 8) begin
            bad++; $display("FAIL bp_hold got=%h/%h push%0d exp=%h/%h push8", {alu_a, alu_b, alu_op}, {res_data, res_op, res_seq}, n_push, alu_snap, head);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 60 && n_pop < 10; c++) begin
            cmd_valid = n_push < 10;
            tick(acc, pp, got, ex);
            if (acc) n_push++;
            if (pp) begin
                total++;
                if (got !== ex) begin bad++; $display("FAIL bp_result[%0d] got=%h exp=%h", n_pop, got, ex); end
                n_pop++;
            end
        end
        cmd_valid = 1'b0;
        total++;
        if (n_pop != 10 || exp_q.size() != 0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL bp_count got=pop%0d left%0d v%b exp=pop10 left0 v0", n_pop, exp_q.size(), res_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic acc, pp;
        logic [18:0] got, ex;
        int errs = 0, n_pop = 0;
        for (int c = 0; c < 400; c++) begin
            cmd_valid = c < 300 && $urandom_range(0, 3) != 0;
            res_ready = c >= 300 || $urandom_range(0, 2) != 0;
            cmd_op = 3'($urandom_range(0, 7)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            tick(acc, pp, got, ex);
            if (pp) begin
                total++;
                n_pop++;
                if (got !== ex) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL b2b_result got=%h exp=%h", got, ex);
                end
            end
        end
        cmd_valid = 1'b0; res_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0 || n_pop < 100) begin
            bad++; $display("FAIL b2b_drain got=busy%b left%0d pops%0d exp=busy0 left0 pops>=100", busy, exp_q.size(), n_pop);
        end
    endtask

    task automatic test_reset_mid;
        logic acc, pp;
        logic [18:0] got, ex;
        int n_pop = 0, stale = 0;
        res_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cmd_valid = 1'b1;
            cmd_op = 3'($urandom_range(0, 7)); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            tick(acc, pp, got, ex);
        end
        cmd_valid = 1'b0;
        tick(acc, pp, got, ex);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0 || {alu_a, alu_b, alu_op} !== '0) begin
            bad++; $display("FAIL rst_mid got=v%b rdy%b busy%b alu=%h exp=v0 rdy0 busy0 alu=0", res_valid, cmd_ready, busy, {alu_a, alu_b, alu_op});
        end
        exp_q.delete();
        seq_m = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(acc, pp, got, ex);
            if (res_valid !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin bad++; $display("FAIL rst_stale got=%0d exp=0", stale); end
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h03; cmd_b = 8'h05;
        tick(acc, pp, got, ex);
        cmd_valid = 1'b0;
        for (int c = 0; c < 10 && n_pop == 0; c++) begin
            tick(acc, pp, got, ex);
            if (pp) begin
                n_pop++;
                total++;
                if (got !== ex || got[7:0] !== 8'd0 || got[18:11] !== 8'hFE) begin
                    bad++; $display("FAIL rst_first got=%h exp=%h", got, ex);
                end
            end
        end
        total++;
        if (n_pop != 1) begin bad++; $display("FAIL rst_timeout got=%0d exp=1", n_pop); end
    endtask

    task automatic test_wrap;
        logic acc, pp;
        logic [18:0] got, ex;
        logic [7:0] prev = 8'd0;
        int n_push = 0, n_pop = 0, errs = 0;
        logic wrapped = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 600 && n_pop < 260; c++) begin
            cmd_valid = n_push < 260;
            cmd_op = 3'd7; cmd_a = seq_m; cmd_b = 8'hFF;
            tick(acc, pp, got, ex);
            if (acc) n_push++;
            if (pp) begin
                total++;
                if (got !== ex || got[18:11] !== ~got[7:0]) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL wrap_result got=%h exp=%h", got, ex);
                end
                if (n_pop > 0 && prev == 8'hFF && got[7:0] == 8'h00) wrapped = 1'b1;
                prev = got[7:0];
                n_pop++;
            end
        end
        cmd_valid = 1'b0;
        total++;
        if (n_pop != 260 || !wrapped) begin
            bad++; $display("FAIL wrap_seq got=pops%0d wrapped%b exp=pops260 wrapped1", n_pop, wrapped);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        seq_m = 8'd0;
        repeat (3) @(negedge clk);
        test_reset;
        test_single_add;
        test_all_ops;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
